// File: rtl/pulse_pkg.sv
// pulse_pkg: shared types and helpers for pulse_stretch_gen.
//   pulse_state_t : FSM state encoding (IDLE, HIGH, GAP)
//   cnt_width()   : width of the phase down-counter, never below 1
package pulse_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        GAP  = 2'd2
    } pulse_state_t;

    // Enough bits to hold max(high_cycles, low_cycles) - 1.
    function automatic int unsigned cnt_width(input int unsigned high_cycles,
                                              input int unsigned low_cycles);
        int unsigned m;
        int unsigned w;
        m = (high_cycles > low_cycles) ? high_cycles : low_cycles;
        w = $clog2(m);
        return (w < 32'd1) ? 32'd1 : w;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter: W-bit up/down counter that saturates at all-ones.
//   clk   : rising-edge clock
//   reset : synchronous active-low reset
//   inc   : request +1
//   dec   : request -1 (inc and dec together cancel)
//   count : registered count value
//   drop  : combinational; an increment is being lost because count is full
module sat_counter #(
    parameter int unsigned W = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         drop
);

    localparam logic [W-1:0] MAX = '1;

    // Net increment with nowhere to go.
    always_comb begin
        drop = 1'b0;
        if (inc && !dec && (count == MAX)) begin
            drop = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (inc && !dec && (count != MAX)) begin
            count <= count + W'(1);
        end else if (dec && !inc && (count != '0)) begin
            count <= count - W'(1);
        end
    end

endmodule

// File: rtl/pulse_stretch_gen.sv
// pulse_stretch_gen: turns one-cycle tick strobes into registered level pulses
// HIGH_CYCLES wide, separated by at least LOW_CYCLES low cycles.
// Ticks arriving during a pulse are queued in a saturating pending counter.
// Build option: define PULSE_RETRIG_EN for retrigger mode (tick in HIGH extends
// the pulse, tick in GAP is a 1-bit request; pend and overflow tied to 0).
//   clk      : rising-edge clock
//   reset    : synchronous active-low reset
//   tick     : event strobe, one event per high cycle
//   clr_ovf  : clears sticky overflow
//   level    : registered stretched pulse
//   busy     : high while in HIGH or GAP
//   pend     : queued events not yet emitted
//   overflow : sticky, set when a tick is dropped on a full queue
module pulse_stretch_gen
    import pulse_pkg::*;
#(
    parameter int unsigned HIGH_CYCLES = 4,
    parameter int unsigned LOW_CYCLES  = 2,
    parameter int unsigned PEND_W      = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick,
    input  logic              clr_ovf,
    output logic              level,
    output logic              busy,
    output logic [PEND_W-1:0] pend,
    output logic              overflow
);

    localparam int unsigned      CNT_W     = cnt_width(HIGH_CYCLES, LOW_CYCLES);
    localparam logic [CNT_W-1:0] HIGH_LOAD = CNT_W'(HIGH_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOW_LOAD  = CNT_W'(LOW_CYCLES - 1);

    pulse_state_t     state;
    logic [CNT_W-1:0] cnt;
    logic             cnt_zero_c;
    logic             go_high_c;
    logic             retrig_c;

    assign cnt_zero_c = (cnt == '0);

`ifdef PULSE_RETRIG_EN
    logic req;
    logic unused_clr_ovf;

    // A tick before the last gap cycle is remembered; the last cycle uses tick directly.
    always_ff @(posedge clk) begin
        if (!reset) begin
            req <= 1'b0;
        end else begin
            req <= (state == GAP) && !cnt_zero_c && (req || tick);
        end
    end

    assign go_high_c      = req || tick;
    assign retrig_c       = tick;
    assign pend           = '0;
    assign overflow       = 1'b0;
    assign unused_clr_ovf = clr_ovf;
`else
    logic inc_c;
    logic dec_c;
    logic drop_c;

    // A tick in the last gap cycle with an empty queue is both queued and
    // consumed at once, so pend stays unchanged.
    assign inc_c     = tick && (state != IDLE);
    assign go_high_c = (pend != '0) || tick;
    assign dec_c     = (state == GAP) && cnt_zero_c && go_high_c;
    assign retrig_c  = 1'b0;

    sat_counter #(
        .W (PEND_W)
    ) u_pend (
        .clk   (clk),
        .reset (reset),
        .inc   (inc_c),
        .dec   (dec_c),
        .count (pend),
        .drop  (drop_c)
    );

    // Sticky overflow; a drop in the same cycle as clr_ovf keeps it set.
    always_ff @(posedge clk) begin
        if (!reset) begin
            overflow <= 1'b0;
        end else if (drop_c) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end
`endif

    // Pulse FSM with registered level/busy.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            level <= 1'b0;
            busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (tick) begin
                        state <= HIGH;
                        cnt   <= HIGH_LOAD;
                        level <= 1'b1;
                        busy  <= 1'b1;
                    end
                end
                HIGH: begin
                    if (retrig_c) begin
                        cnt <= HIGH_LOAD;
                    end else if (cnt_zero_c) begin
                        state <= GAP;
                        cnt   <= LOW_LOAD;
                        level <= 1'b0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                GAP: begin
                    if (cnt_zero_c) begin
                        if (go_high_c) begin
                            state <= HIGH;
                            cnt   <= HIGH_LOAD;
                            level <= 1'b1;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    level <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_stretch_gen.sv
// tb_pulse_stretch_gen: directed bench for pulse_stretch_gen with HIGH=4,
// LOW=2, PEND_W=2. Each step checks {level,busy,pend,overflow} at the
// falling edge, then drives the inputs for the next rising edge.
module tb_pulse_stretch_gen;

    localparam int unsigned PW = 2;

    logic          clk;
    logic          reset;
    logic          tick;
    logic          clr_ovf;
    logic          level;
    logic          busy;
    logic [PW-1:0] pend;
    logic          overflow;

    int checks = 0;
    int errors = 0;

    pulse_stretch_gen #(
        .HIGH_CYCLES (4),
        .LOW_CYCLES  (2),
        .PEND_W      (PW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .tick     (tick),
        .clr_ovf  (clr_ovf),
        .level    (level),
        .busy     (busy),
        .pend     (pend),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Check current outputs, then apply inputs for one cycle.
    task automatic run(input logic r, input logic t, input logic c,
                       input logic el, input logic eb, input logic [PW-1:0] ep,
                       input logic eo, input string tag);
        logic [PW+2:0] obs;
        logic [PW+2:0] exp;
        obs = {level, busy, pend, overflow};
        exp = {el, eb, ep, eo};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: {level,busy,pend,ovf} observed %b expected %b", tag, obs, exp);
        end
        reset   = r;
        tick    = t;
        clr_ovf = c;
        @(negedge clk);
    endtask

    initial begin
        reset   = 1'b0;
        tick    = 1'b0;
        clr_ovf = 1'b0;
        @(negedge clk);

        // Reset state
        repeat (2) run(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, "reset");
        repeat (2) run(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, "idle");

        // Single tick: 4 high, 2 low, then idle
        run(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, "A.tick");
        repeat (4) run(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, "A.high");
        repeat (2) run(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, "A.gap");
        run(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, "A.idle");

        // Reset truncates a pulse
        run(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, "R.tick");
        run(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, "R.high1");
        run(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, "R.high2");
        run(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, "R.after");

`ifndef PULSE_RETRIG_EN
        // Three consecutive ticks: pulses back to back with period 6
        run(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, "B.c10");
        run(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, "B.c11");
        run(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 1'b0, "B.c12");
        repeat (2) run(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd2, 1'b0, "B.p1");
        repeat (2) run(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, "B.g1");
        repeat (4) run(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 1'b0, "B.p2");
        repeat (2) run(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, "B.g2");
        repeat (4) run(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, "B.p3");
        repeat (2) run(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, "B.g3");
        run(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, "B.idle");

        // Tick in the last gap cycle with empty queue
        run(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, "D.tick");
        repeat (4) run(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, "D.p1");
        run(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, "D.gap");
        run(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, "D.gap_last");
        repeat (4) run(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, "D.p2");
        repeat (2) run(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, "D.g2");
        run(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, "D.idle");

        // Queue full, overflow set/clear priority, reset with pend=2
        run(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, "C.c0");
        run(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, "C.c1");
        run(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 1'b0, "C.c2");
        run(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'd2, 1'b0, "C.c3");
        run(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'd3, 1'b0, "C.c4_drop");
        run(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'd3, 1'b1, "C.c5_drop_clr");
        run(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd3, 1'b1, "C.c6_clr");
        run(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd2, 1'b0, "C.c7");
        run(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd2, 1'b0, "C.c8_rst");
        run(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, "C.c9_after_rst");
        run(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, "C.idle");
`else
        // Retrigger: second tick extends to 6 high cycles; gap tick latches
        run(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, "T.c10");
        run(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, "T.c11");
        run(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, "T.c12");
        repeat (4) run(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, "T.ext");
        run(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, "T.gap_tick");
        run(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, "T.gap_last");
        repeat (4) run(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, "T.p2");
        repeat (2) run(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, "T.g2");
        run(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, "T.idle");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pulse_stretch_gen.md
# pulse_stretch_gen

Converts single-cycle `tick` strobes into clean, registered `level` pulses of fixed high width with a guaranteed minimum low gap. This is the inverse of the level-to-tick edge detector. It drives LEDs, slow peripherals and downstream edge detectors from one-cycle event strobes. Ticks that arrive while a pulse is in progress are queued in a saturating pending counter, so no event is lost silently.

## Interface
Parameters:
- `HIGH_CYCLES`, default 4: cycles `level` is held high per pulse; legal range ≥1.
- `LOW_CYCLES`, default 2: minimum cycles `level` is low between pulses; legal range ≥1.
- `PEND_W`, default 3: pending-counter width; the queue holds up to 2^PEND_W−1 ticks.

Ports:
- `clk`, input, 1: rising-edge clock, the only clock.
- `reset`, input, 1: synchronous, active-low reset, sampled on `clk` rising edge.
- `tick`, input, 1: event strobe; each high cycle is one event.
- `clr_ovf`, input, 1: clears the sticky `overflow` flag.
- `level`, output, 1: registered stretched pulse.
- `busy`, output, 1: high while in state HIGH or GAP.
- `pend`, output, PEND_W: number of queued events not yet emitted.
- `overflow`, output, 1: sticky; set when a tick is dropped because the queue is full.

## Operation
- FSM states:
  - IDLE: `level`=0.
  - HIGH: `level`=1; down-counter loaded with HIGH_CYCLES−1.
  - GAP: `level`=0; counter loaded with LOW_CYCLES−1.
- IDLE→HIGH on `tick`=1.
- HIGH→GAP when the counter reaches 0.
- GAP, when the counter reaches 0:
  - if `pend`>0 or `tick`=1: go to HIGH and consume one event.
  - otherwise: go to IDLE.
- Queue:
  - `tick` in HIGH or GAP increments `pend`.
  - Consuming an event at GAP→HIGH decrements `pend`.
  - If both happen in the same cycle, `pend` is unchanged.
  - If `tick` arrives in the final GAP cycle with `pend`=0, the tick starts the next pulse directly and `pend` stays 0.
- Saturation: when `pend` = 2^PEND_W−1, a tick that is not offset by a consume is dropped. `pend` holds and `overflow` is set to 1.
- `overflow` clears on `clr_ovf`=1. If a drop and `clr_ovf` occur in the same cycle, set wins.
- Counter width is $clog2(max(HIGH_CYCLES, LOW_CYCLES)) and never less than 1. Comparisons are unsigned.

## Timing
- Reset (`reset`=0 at an edge) forces: state IDLE, `level`=0, `busy`=0, `pend`=0, `overflow`=0, counter 0. Reset applies mid-pulse too; the pulse is truncated at that edge.
- All outputs are registered. There is no combinational path from `tick` to any output.
- Latency: with `tick` high in cycle t while IDLE, `level` is high in cycles t+1 … t+HIGH_CYCLES and low for at least cycles t+HIGH_CYCLES+1 … t+HIGH_CYCLES+LOW_CYCLES.
- Back-to-back queued events give a period of exactly HIGH_CYCLES+LOW_CYCLES with no extra idle cycle.
- `tick` held high for N cycles counts as N events.

## Configuration
- `PULSE_RETRIG_EN` defined (retrigger mode):
  - `tick` during HIGH reloads the counter to HIGH_CYCLES−1, extending the current pulse.
  - `tick` during GAP is latched as a 1-bit request that starts the next pulse when the gap ends.
  - `pend` is tied to 0 and `overflow` is tied to 0.
- `PULSE_RETRIG_EN` undefined: the queued behaviour described above. This is the default build.

## Structure
- Shared package `pulse_pkg`: FSM state enumeration (IDLE, HIGH, GAP) and the counter-width helper function.
- One natural sub-module: `sat_counter`, a PEND_W-bit up/down saturating counter with inc/dec inputs and a `drop` output. It is excluded in retrigger builds.

## Test plan
- Reset, then a single tick at cycle 10 with HIGH=4, LOW=2: `level`=1 in cycles 11–14, 0 from cycle 15; `busy` falls at cycle 17.
- 3 ticks on consecutive cycles starting at 10: `pend` goes 1, 2, then decrements. Pulses start at cycles 11, 17 and 23, each 4 high / 2 low.
- Queue-full case, PEND_W=2: 5 ticks during HIGH → `pend` saturates at 3 and `overflow`=1. A later `clr_ovf` pulse clears it; `clr_ovf` and a drop in the same cycle leave it at 1.
- Tick in the final GAP cycle with `pend`=0: the next pulse starts the following cycle and `pend` stays 0.
- `reset`=0 during cycle 2 of HIGH with `pend`=2: the next cycle shows `level`=0, `pend`=0 and state IDLE.
- With `PULSE_RETRIG_EN`: tick at cycle 10 and a second tick at cycle 12 → `level` high in cycles 11–16, `pend` stays 0.
